// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder
//   Turns the byte stream of a PS/2 set-2 receiver into key events and keeps
//   a live "held" bitmap for WASD and the four arrow keys.
//
//   Ports
//     clk          in   system clock, everything on posedge
//     rst_n        in   asynchronous active-low reset
//     keycode[7:0] in   received byte, qualified by oflag
//     oflag        in   one-clk strobe: keycode holds a new byte
//     key_code[7:0]out  final scancode byte of the last event
//     key_ext      out  last event carried the E0 prefix
//     key_release  out  last event was a break (F0)
//     key_valid    out  one-clk strobe: key_code/key_ext/key_release are new
//     key_held[7:0]out  W A S D Up Left Down Right (bit0..bit7)
//     seq_err      out  one-clk strobe on timeout or keyboard error byte
//
//   TIMEOUT_CYCLES: maximum idle clk cycles between bytes of one sequence.
module ps2_key_decoder #(
  parameter int unsigned TIMEOUT_CYCLES = 2_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] keycode,
  input  logic       oflag,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_release,
  output logic       key_valid,
  output logic [7:0] key_held,
  output logic       seq_err
);

  localparam int unsigned TW =
    ($clog2(TIMEOUT_CYCLES) > 21) ? $clog2(TIMEOUT_CYCLES) : 21;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    EXT,
    BRK,
    EXT_BRK,
    SKIP
  } state_t;

  state_t        r_state;
  logic [2:0]    r_skip_cnt;
  logic [TW-1:0] r_tmo_cnt;
  logic [7:0]    r_key_code;
  logic          r_key_ext;
  logic          r_key_release;
  logic          r_key_valid;
  logic [7:0]    r_key_held;
  logic          r_seq_err;

  logic          w_is_e0;
  logic          w_is_f0;
  logic          w_is_e1;
  logic          w_quiet;
  logic          w_bad;
  logic          w_emit;
  logic          w_ext;
  logic          w_rel;
  logic [7:0]    w_mask;

  // Held-bitmap position for a final byte; the E0 status must match.
  function automatic logic [7:0] held_mask(input logic [7:0] code,
                                           input logic       ext);
    held_mask = '0;
    if (!ext) begin
      case (code)
        8'h1D:   held_mask[0] = 1'b1;
        8'h1C:   held_mask[1] = 1'b1;
        8'h1B:   held_mask[2] = 1'b1;
        8'h23:   held_mask[3] = 1'b1;
        default: held_mask = '0;
      endcase
    end else begin
      case (code)
        8'h75:   held_mask[4] = 1'b1;
        8'h6B:   held_mask[5] = 1'b1;
        8'h72:   held_mask[6] = 1'b1;
        8'h74:   held_mask[7] = 1'b1;
        default: held_mask = '0;
      endcase
    end
  endfunction

  always_comb begin
    w_is_e0 = (keycode == 8'hE0);
    w_is_f0 = (keycode == 8'hF0);
    w_is_e1 = (keycode == 8'hE1);
    w_quiet = (keycode == 8'hAA) || (keycode == 8'hFA) ||
              (keycode == 8'hEE) || (keycode == 8'hFE);
    w_bad   = (keycode == 8'h00) || (keycode == 8'hFF);
    w_ext   = (r_state == EXT) || (r_state == EXT_BRK);
    w_rel   = (r_state == BRK) || (r_state == EXT_BRK);
    w_emit  = 1'b0;
    if (oflag && !w_quiet && !w_bad) begin
      case (r_state)
        IDLE:             w_emit = !w_is_e0 && !w_is_f0 && !w_is_e1;
        EXT, BRK, EXT_BRK: w_emit = !w_is_e0 && !w_is_f0;
        default:          w_emit = 1'b0;
      endcase
    end
    w_mask = held_mask(keycode, w_ext);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_skip_cnt    <= '0;
      r_tmo_cnt     <= '0;
      r_key_code    <= '0;
      r_key_ext     <= 1'b0;
      r_key_release <= 1'b0;
      r_key_valid   <= 1'b0;
      r_key_held    <= '0;
      r_seq_err     <= 1'b0;
    end else begin
      r_key_valid <= 1'b0;
      r_seq_err   <= 1'b0;

      if (w_emit) begin
        r_key_code    <= keycode;
        r_key_ext     <= w_ext;
        r_key_release <= w_rel;
        r_key_valid   <= 1'b1;
        r_key_held    <= w_rel ? (r_key_held & ~w_mask) : (r_key_held | w_mask);
      end

      if (oflag) begin
        // A new byte always wins over a timeout detected on the same cycle.
        r_tmo_cnt <= '0;
        if (w_quiet) begin
          r_state <= IDLE;
        end else if (w_bad) begin
          r_state   <= IDLE;
          r_seq_err <= 1'b1;
        end else begin
          case (r_state)
            IDLE: begin
              if (w_is_e0)      r_state <= EXT;
              else if (w_is_f0) r_state <= BRK;
              else if (w_is_e1) begin
                r_state    <= SKIP;
                r_skip_cnt <= 3'd7;
              end
            end
            EXT: begin
              if (w_is_f0)       r_state <= EXT_BRK;
              else if (!w_is_e0) r_state <= IDLE;
            end
            BRK: begin
              if (w_is_e0)       r_state <= EXT_BRK;
              else if (!w_is_f0) r_state <= IDLE;
            end
            EXT_BRK: begin
              if (!w_is_e0 && !w_is_f0) r_state <= IDLE;
            end
            SKIP: begin
              r_skip_cnt <= r_skip_cnt - 3'd1;
              if (r_skip_cnt == 3'd1) r_state <= IDLE;
            end
            default: r_state <= IDLE;
          endcase
        end
      end else if (r_state != IDLE) begin
        if (r_tmo_cnt == TMO_LAST) begin
          r_state    <= IDLE;
          r_tmo_cnt  <= '0;
          r_skip_cnt <= '0;
          r_seq_err  <= 1'b1;
        end else begin
          r_tmo_cnt <= r_tmo_cnt + 1'b1;
        end
      end else begin
        r_tmo_cnt <= '0;
      end
    end
  end

  assign key_code    = r_key_code;
  assign key_ext     = r_key_ext;
  assign key_release = r_key_release;
  assign key_valid   = r_key_valid;
  assign key_held    = r_key_held;
  assign seq_err     = r_seq_err;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Scoreboard bench for ps2_key_decoder with a short timeout.
module tb_ps2_key_decoder;

  localparam int unsigned TMO = 16;

  logic       clk;
  logic       rst_n;
  logic [7:0] keycode;
  logic       oflag;
  logic [7:0] key_code;
  logic       key_ext;
  logic       key_release;
  logic       key_valid;
  logic [7:0] key_held;
  logic       seq_err;

  ps2_key_decoder #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .keycode    (keycode),
    .oflag      (oflag),
    .key_code   (key_code),
    .key_ext    (key_ext),
    .key_release(key_release),
    .key_valid  (key_valid),
    .key_held   (key_held),
    .seq_err    (seq_err)
  );

  typedef struct packed {
    logic       err;
    logic [7:0] code;
    logic       ext;
    logic       rel;
    logic [7:0] held;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic put(input logic [7:0] b);
    @(negedge clk);
    keycode = b;
    oflag   = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      oflag = 1'b0;
    end
  endtask

  task automatic send(input logic [7:0] b);
    put(b);
    idle(1);
  endtask

  task automatic push_ev(input logic [7:0] c, input logic e, input logic r, input logic [7:0] h);
    exp_t x;
    x.err = 1'b0; x.code = c; x.ext = e; x.rel = r; x.held = h;
    q.push_back(x);
  endtask

  task automatic push_err();
    exp_t x;
    x = '0;
    x.err = 1'b1;
    q.push_back(x);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 40 && q.size() != 0; i++) @(negedge clk);
    chk(tag, q.size(), 0);
  endtask

  // Every strobe cycle consumes exactly one expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && (key_valid || seq_err)) begin
      if (key_valid && seq_err) chk("both_strobes", 1, 0);
      if (q.size() == 0) begin
        chk("unexpected_strobe", {22'd0, key_valid, seq_err, key_code}, 0);
      end else begin
        exp_t x;
        x = q.pop_front();
        if (x.err) begin
          chk("err_kind", {seq_err, key_valid}, 2'b10);
        end else begin
          chk("ev_kind", {seq_err, key_valid}, 2'b01);
          chk("ev_code", key_code, x.code);
          chk("ev_ext",  key_ext,  x.ext);
          chk("ev_rel",  key_release, x.rel);
          chk("ev_held", key_held, x.held);
        end
      end
    end
  end

  initial begin
    rst_n   = 1'b0;
    keycode = '0;
    oflag   = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_code",  key_code, 8'h00);
    chk("rst_held",  key_held, 8'h00);
    chk("rst_flags", {key_ext, key_release, key_valid, seq_err}, 4'b0000);
    rst_n = 1'b1;
    idle(2);

    // Plain make/break of W
    push_ev(8'h1D, 0, 0, 8'h01); send(8'h1D);
    send(8'hF0); push_ev(8'h1D, 0, 1, 8'h00); send(8'h1D);
    drain("drain_w");

    // Extended Right, then plain 74 leaves bit7 alone
    send(8'hE0); push_ev(8'h74, 1, 0, 8'h80); send(8'h74);
    send(8'hE0); send(8'hF0); push_ev(8'h74, 1, 1, 8'h00); send(8'h74);
    push_ev(8'h74, 0, 0, 8'h00); send(8'h74);
    drain("drain_right");

    // Pause sequence back-to-back, then A with no gap
    push_ev(8'h1C, 0, 0, 8'h02);
    put(8'hE1); put(8'h14); put(8'h77); put(8'hE1);
    put(8'hF0); put(8'h14); put(8'hF0); put(8'h77); put(8'h1C);
    idle(1);
    drain("drain_pause");

    // Timeout after a lone E0, then D decodes as plain
    send(8'hE0);
    push_err();
    idle(TMO + 4);
    drain("drain_tmo");
    push_ev(8'h23, 0, 0, 8'h0A); send(8'h23);
    drain("drain_d");

    // Error byte after F0, then quiet byte
    send(8'hF0); push_err(); send(8'hFF);
    send(8'hAA);
    idle(3);
    drain("drain_errbyte");
    chk("held_after_err", key_held, 8'h0A);

    // Fill key_held; plain 75 is not Up
    push_ev(8'h75, 0, 0, 8'h0A); send(8'h75);
    push_ev(8'h1D, 0, 0, 8'h0B); send(8'h1D);
    push_ev(8'h1B, 0, 0, 8'h0F); send(8'h1B);
    send(8'hE0); push_ev(8'h75, 1, 0, 8'h1F); send(8'h75);
    send(8'hE0); push_ev(8'h6B, 1, 0, 8'h3F); send(8'h6B);
    send(8'hE0); push_ev(8'h72, 1, 0, 8'h7F); send(8'h72);
    put(8'hE0); push_ev(8'h74, 1, 0, 8'hFF); put(8'h74); idle(1);
    drain("drain_fill");
    chk("held_full", key_held, 8'hFF);

    // Reset in the middle of E0 F0
    send(8'hE0); send(8'hF0);
    rst_n = 1'b0;
    #1;
    chk("midrst_held", key_held, 8'h00);
    chk("midrst_code", key_code, 8'h00);
    chk("midrst_flags", {key_ext, key_release, key_valid, seq_err}, 4'b0000);
    idle(2);
    rst_n = 1'b1;
    idle(1);
    push_ev(8'h6B, 0, 0, 8'h00); send(8'h6B);
    drain("drain_6b");

    idle(5);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ps2_key_decoder.md
PS2_KEY_DECODER -- requirements
Module: ps2_key_decoder

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 2_000_000, the maximum idle clk cycles allowed between bytes of one multi-byte scancode sequence.
REQ-002 SHALL have port clk, input, 1, the single system clock; all logic on posedge clk.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port keycode, input, 8, the received PS/2 set-2 byte from the upstream receiver.
REQ-005 SHALL have port oflag, input, 1, a one-clk strobe marking keycode as a new byte.
REQ-006 SHALL have port key_code, output, 8, the final scancode byte of the last decoded event.
REQ-007 SHALL have port key_ext, output, 1, which is 1 when the last event carried the E0 prefix.
REQ-008 SHALL have port key_release, output, 1, which is 1 when the last event was a break (F0) and 0 when it was a make.
REQ-009 SHALL have port key_valid, output, 1, a one-clk strobe marking key_code/key_ext/key_release as new.
REQ-010 SHALL have port key_held, output, 8, live held state: bit0 W(1D), bit1 A(1C), bit2 S(1B), bit3 D(23), bit4 Up(E0 75), bit5 Left(E0 6B), bit6 Down(E0 72), bit7 Right(E0 74).
REQ-011 SHALL have port seq_err, output, 1, a one-clk strobe on timeout or keyboard error byte.

Function
REQ-012 SHALL use FSM states IDLE, EXT, BRK, EXT_BRK, SKIP; bytes are consumed only on cycles with oflag=1.
REQ-013 SHALL transition IDLE: E0->EXT, F0->BRK, E1->SKIP (skip counter=7), any other non-special byte->emit make event, stay IDLE.
REQ-014 SHALL transition EXT: F0->EXT_BRK, E0->stay, other->emit ext make, go IDLE.
REQ-015 SHALL transition BRK: E0->EXT_BRK, F0->stay, other->emit break, go IDLE.
REQ-016 SHALL transition EXT_BRK: E0/F0->stay, other->emit ext break, go IDLE.
REQ-017 SHALL, in SKIP, decrement the counter per byte with no event, going to IDLE when a byte arrives with counter=1 (Pause sequence E1 14 77 E1 F0 14 F0 77 yields zero events).
REQ-018 SHALL treat special bytes AA, FA, EE, FE in any state: discard, go IDLE, no event, no seq_err.
REQ-019 SHALL treat special bytes 00, FF in any state: discard, go IDLE, pulse seq_err.
REQ-020 SHALL assert key_valid exactly in the cycle after the oflag cycle carrying the final byte, with key_code/key_ext/key_release updated on the same edge and held until the next event.
REQ-021 SHALL update key_held on the same edge as key_valid: make sets the mapped bit, break clears it; E0 status must match the mapping (plain 75 does not affect bit4); unmapped codes leave key_held unchanged.
REQ-022 SHALL reload the 21-bit+ timeout counter to 0 on every oflag, increment it each cycle while state is not IDLE, and hold it at 0 in IDLE.
REQ-023 SHALL, when the timeout counter reaches TIMEOUT_CYCLES-1 without oflag, go IDLE, pulse seq_err next cycle, and emit no event; oflag on that same cycle wins (byte processed normally, no timeout).
REQ-024 SHALL ensure key_valid and seq_err are never asserted in the same cycle and never for more than one consecutive cycle per cause.
REQ-025 SHALL accept back-to-back oflag on consecutive cycles without byte loss.

Reset
REQ-026 SHALL, on rst_n=0, immediately force state=IDLE, counters=0, key_code=00, key_ext=0, key_release=0, key_valid=0, key_held=00, seq_err=0.
REQ-027 SHALL, when reset is asserted mid-sequence, discard the partial sequence; the first byte after release is decoded from IDLE.

Verification
REQ-028 SHALL cover: bytes 1D, then F0 1D -> key_valid twice: (1D,ext0,rel0), key_held=01; then (1D,ext0,rel1), key_held=00.
REQ-029 SHALL cover: bytes E0 74, then E0 F0 74 -> (74,ext1,rel0), key_held bit7=1; then (74,ext1,rel1), bit7=0; plain 74 alone leaves bit7=0.
REQ-030 SHALL cover: E1 14 77 E1 F0 14 F0 77 followed by 1C -> exactly one key_valid, (1C,0,0), key_held=02.
REQ-031 SHALL cover: E0, then no byte for TIMEOUT_CYCLES clk, then 23 -> one seq_err pulse, then (23,ext0,rel0), not extended.
REQ-032 SHALL cover: F0, then FF -> seq_err pulse, no event; then AA -> no event, no seq_err; held bits unchanged.
REQ-033 SHALL cover: rst_n low after E0 F0 with key_held=FF -> outputs cleared at once; after release, 6B -> (6B,ext0,rel0), key_held=00.
